// File: rtl/random_ctrl.sv
// Galois LFSR random-number custom instruction with start/done handshake.
// Opcodes: NEXT, SEED, RANGE (restoring modulo, 33-cycle latency), PEEK.
module random_ctrl #(
  parameter logic [31:0] LFSR_MASK    = 32'h80200003,
  parameter logic [31:0] SEED_DEFAULT = 32'h00000001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  output logic        done,
  output logic [31:0] result
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 5;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MOD  = 1'b1
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [DW-1:0]   r_lfsr, w_lfsr_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [DW:0]     r_rem, w_rem_nxt;
  logic [DW-1:0]   r_dvd, w_dvd_nxt;
  logic [DW-1:0]   r_dvs, w_dvs_nxt;
  logic            r_done, w_done_nxt;
  logic [DW-1:0]   r_result, w_result_nxt;

  logic [DW-1:0]   w_lfsr_step;
  logic [DW-1:0]   w_seed;
  logic [DW:0]     w_rem_sh;
  logic [DW:0]     w_rem_sub;
  logic [DW:0]     w_rem_new;
  logic            w_ge;
  logic            w_unused_bits;

  assign w_lfsr_step = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_MASK) : (r_lfsr >> 1);
  assign w_seed      = (dataB == '0) ? SEED_DEFAULT : dataB;

  // One restoring-division step: shift in next dividend bit, subtract if it fits.
  assign w_rem_sh  = {r_rem[DW-1:0], r_dvd[DW-1]};
  assign w_rem_sub = w_rem_sh - {1'b0, r_dvs};
  assign w_ge      = (w_rem_sh >= {1'b0, r_dvs});
  assign w_rem_new = w_ge ? w_rem_sub : w_rem_sh;

  // Opcode upper bits and remainder MSB never feed logic.
  assign w_unused_bits = &{1'b0, dataA[31:2], r_rem[DW]};

  always_comb begin
    w_state_nxt  = r_state;
    w_lfsr_nxt   = r_lfsr;
    w_cnt_nxt    = r_cnt;
    w_rem_nxt    = r_rem;
    w_dvd_nxt    = r_dvd;
    w_dvs_nxt    = r_dvs;
    w_done_nxt   = 1'b0;
    w_result_nxt = r_result;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          case (dataA[1:0])
            2'b00: begin
              w_lfsr_nxt   = w_lfsr_step;
              w_result_nxt = w_lfsr_step;
              w_done_nxt   = 1'b1;
            end
            2'b01: begin
              w_lfsr_nxt   = w_seed;
              w_result_nxt = w_seed;
              w_done_nxt   = 1'b1;
            end
            2'b10: begin
              w_lfsr_nxt  = w_lfsr_step;
              w_dvd_nxt   = w_lfsr_step;
              w_dvs_nxt   = dataB;
              w_rem_nxt   = '0;
              w_cnt_nxt   = '0;
              w_state_nxt = S_MOD;
            end
            default: begin
              w_result_nxt = r_lfsr;
              w_done_nxt   = 1'b1;
            end
          endcase
        end
      end
      S_MOD: begin
        w_rem_nxt = w_rem_new;
        w_dvd_nxt = r_dvd << 1;
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == CW'(DW - 1)) begin
          w_state_nxt  = S_IDLE;
          w_done_nxt   = 1'b1;
          w_result_nxt = w_rem_new[DW-1:0];
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // All state advances only on clk_en-qualified edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_lfsr   <= SEED_DEFAULT;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else if (clk_en) begin
      r_state  <= w_state_nxt;
      r_lfsr   <= w_lfsr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rem    <= w_rem_nxt;
      r_dvd    <= w_dvd_nxt;
      r_dvs    <= w_dvs_nxt;
      r_done   <= w_done_nxt;
      r_result <= w_result_nxt;
    end
  end

  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_random_ctrl.sv
// Randomized and directed checks of random_ctrl against a behavioural
// model that tracks the LFSR value and computes results with plain arithmetic.
module tb_random_ctrl;

  localparam logic [31:0] MASK     = 32'h80200003;
  localparam logic [31:0] SEED_DEF = 32'h00000001;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        start;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic        done;
  logic [31:0] result;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] m_lfsr;

  always #5 clk = ~clk;

  random_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .start  (start),
    .dataA  (dataA),
    .dataB  (dataB),
    .done   (done),
    .result (result)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic [31:0] fb;
    fb = (s % 2 == 1) ? MASK : 32'h0;
    return (s / 2) ^ fb;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] op_word(input logic [1:0] op);
    logic [31:0] w;
    w = $urandom() & 32'hFFFF_FFFC;
    return w | 32'(op);
  endfunction

  task automatic apply_reset();
    reset  = 1'b0;
    start  = 1'b0;
    clk_en = 1'b1;
    #1;
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    reset  = 1'b1;
    m_lfsr = SEED_DEF;
  endtask

  // Latency-1 opcodes: NEXT, SEED, PEEK.
  task automatic single(input logic [1:0] op, input logic [31:0] b);
    logic [31:0] exp;
    case (op)
      2'b00:   begin m_lfsr = lfsr_next(m_lfsr); exp = m_lfsr; end
      2'b01:   begin m_lfsr = (b == 0) ? SEED_DEF : b; exp = m_lfsr; end
      default: exp = m_lfsr;
    endcase
    dataA  = op_word(op);
    dataB  = b;
    clk_en = 1'b1;
    start  = 1'b1;
    step();
    start = 1'b0;
    dataB = $urandom();
    check("single_done", 32'(done), 32'd1);
    check("single_result", result, exp);
    step();
    check("single_done_width", 32'(done), 32'd0);
  endtask

  // RANGE with optional clk_en gap and spurious starts (1: at C5/C20, 2: random).
  task automatic range_op(input logic [31:0] b, input int gap_at, input int gap_len, input int spur);
    logic [31:0] exp;
    int lat;
    m_lfsr = lfsr_next(m_lfsr);
    exp    = (b == 0) ? m_lfsr : (m_lfsr % b);
    dataA  = op_word(2'b10);
    dataB  = b;
    clk_en = 1'b1;
    start  = 1'b1;
    step();
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 200) begin
      clk_en = !(gap_len > 0 && lat >= gap_at && lat < gap_at + gap_len);
      start  = (spur == 1 && (lat == 5 || lat == 20)) ||
               (spur == 2 && $urandom_range(0, 3) == 0);
      dataA  = $urandom();
      dataB  = $urandom();
      step();
      lat++;
    end
    start  = 1'b0;
    clk_en = 1'b1;
    check("range_done", 32'(done), 32'd1);
    check("range_latency", 32'(lat), 32'(33 + gap_len));
    check("range_result", result, exp);
    step();
    check("range_done_width", 32'(done), 32'd0);
  endtask

  // Back-to-back accepted starts, one per cycle.
  task automatic back_to_back();
    logic [1:0]  ops [4];
    logic [31:0] bs  [4];
    logic [31:0] exp;
    ops[0] = 2'b00; ops[1] = 2'b11; ops[2] = 2'b01; ops[3] = 2'b00;
    for (int i = 0; i < 4; i++) bs[i] = $urandom();
    clk_en = 1'b1;
    start  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      case (ops[i])
        2'b00:   begin m_lfsr = lfsr_next(m_lfsr); exp = m_lfsr; end
        2'b01:   begin m_lfsr = (bs[i] == 0) ? SEED_DEF : bs[i]; exp = m_lfsr; end
        default: exp = m_lfsr;
      endcase
      dataA = op_word(ops[i]);
      dataB = bs[i];
      step();
      check("b2b_done", 32'(done), 32'd1);
      check("b2b_result", result, exp);
    end
    start = 1'b0;
    step();
    check("b2b_done_end", 32'(done), 32'd0);
  endtask

  initial begin
    logic [31:0] r_ref;
    logic [31:0] b;
    int          op;
    reset  = 1'b0;
    clk_en = 1'b0;
    start  = 1'b0;
    dataA  = '0;
    dataB  = '0;
    m_lfsr = SEED_DEF;

    apply_reset();
    single(2'b00, 32'h0);
    check("next1_const", result, 32'h80200003);
    single(2'b00, 32'h0);
    check("next2_const", result, 32'hC0300002);
    single(2'b11, 32'h0);
    check("peek_const", result, 32'hC0300002);

    apply_reset();
    range_op(32'd10, 0, 0, 1);
    check("range10_const", result, 32'd3);

    single(2'b01, 32'h12345678);
    single(2'b11, 32'h0);
    check("seed_peek_const", result, 32'h12345678);
    single(2'b01, 32'h0);
    single(2'b11, 32'h0);
    check("seed0_peek_const", result, 32'h00000001);

    apply_reset();
    range_op(32'd0, 0, 0, 0);
    check("range0_const", result, 32'h80200003);
    range_op(32'd1, 0, 0, 0);
    check("range1_const", result, 32'd0);

    // Gapped RANGE must match the uninterrupted result.
    single(2'b01, 32'hDEADBEEF);
    range_op(32'd1000, 0, 0, 0);
    r_ref = result;
    single(2'b01, 32'hDEADBEEF);
    range_op(32'd1000, 10, 5, 0);
    check("gap_same_result", result, r_ref);

    // done and result hold while clk_en is low.
    m_lfsr = lfsr_next(m_lfsr);
    dataA  = op_word(2'b00);
    start  = 1'b1;
    step();
    start  = 1'b0;
    clk_en = 1'b0;
    step();
    check("hold_done", 32'(done), 32'd1);
    check("hold_result", result, m_lfsr);
    clk_en = 1'b1;
    step();
    check("hold_done_release", 32'(done), 32'd0);

    back_to_back();

    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'd1;
        2:       b = $urandom_range(2, 100);
        default: b = $urandom();
      endcase
      if (op == 2) begin
        if ($urandom_range(0, 1) == 1)
          range_op(b, $urandom_range(1, 25), $urandom_range(1, 6), 2);
        else
          range_op(b, 0, 0, 2);
      end else begin
        single(2'(op), b);
      end
    end

    // Asynchronous reset in the middle of a RANGE.
    single(2'b01, 32'h0000_0F0F);
    dataA  = op_word(2'b10);
    dataB  = 32'd7;
    start  = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    check("pre_abort_done", 32'(done), 32'd0);
    #3;
    reset = 1'b0;
    #1;
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", result, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    reset  = 1'b1;
    m_lfsr = SEED_DEF;
    single(2'b00, 32'h0);
    check("post_abort_next", result, 32'h80200003);
    repeat (40) begin
      step();
      check("post_abort_no_done", 32'(done), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/random_ctrl.md
RANDOM_CTRL -- requirements
Module: random_ctrl

Interface
REQ-001 Parameter LFSR_MASK, default 32'h80200003, Galois feedback mask (x^32+x^22+x^2+x+1, right-shift form).
REQ-002 Parameter SEED_DEFAULT, default 32'h00000001, LFSR reset/zero-seed value; SHALL be nonzero.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 clk_en  input  1  clock qualifier; when low, every register holds its value.
REQ-006 start  input  1  one-cycle operation request.
REQ-007 dataA  input  32  opcode in dataA[1:0]; dataA[31:2] ignored.
REQ-008 dataB  input  32  operand: seed value (SEED) or modulus (RANGE).
REQ-009 done  output  1  registered one-cycle completion pulse.
REQ-010 result  output  32  registered operation result; holds until the next completion.

Function
REQ-011 The block SHALL sequence a 32-bit Galois LFSR behind a multi-cycle start/done custom-instruction handshake.
REQ-012 LFSR step SHALL be: lsb=1 -> state = (state>>1) ^ LFSR_MASK; lsb=0 -> state = state>>1.
REQ-013 FSM states SHALL be IDLE and MOD only; start is sampled only in IDLE with clk_en=1.
REQ-014 Opcode 00 NEXT: step LFSR once; result = new state; done high in the next cycle (latency 1).
REQ-015 Opcode 01 SEED: state = dataB (dataB=0 -> SEED_DEFAULT); result = loaded state; latency 1.
REQ-016 Opcode 10 RANGE: step LFSR at the sampling edge, enter MOD; result = new state mod dataB.
REQ-017 MOD SHALL perform 32 restoring-division iterations, one per clk_en cycle, MSB first, with a 33-bit partial remainder; no divider operator.
REQ-018 RANGE latency SHALL be 33 cycles (start in C0, iterations at edges ending C1..C32, done high in C33); FSM returns to IDLE at the edge that sets done.
REQ-019 RANGE with dataB=0 SHALL return the raw new state after the same 33-cycle latency.
REQ-020 Opcode 11 PEEK: result = current state, LFSR unchanged; latency 1.
REQ-021 dataB SHALL be latched at the sampling edge; later dataB changes do not affect an operation in progress.
REQ-022 done SHALL be high for exactly one clk_en-qualified cycle per accepted start, low otherwise.
REQ-023 start while in MOD SHALL be ignored: no queueing, no extra done, no state change.
REQ-024 start in the same cycle done is high (FSM in IDLE) SHALL be accepted; NEXT/PEEK/SEED sustain one operation per cycle.
REQ-025 With clk_en low, FSM, iteration counter, LFSR, done and result SHALL hold; start is not sampled; operation resumes unchanged when clk_en returns high.
REQ-026 LFSR state SHALL never become zero.

Reset
REQ-027 reset low SHALL immediately force FSM=IDLE, LFSR=SEED_DEFAULT, counter=0, done=0, result=0, regardless of clk or clk_en.
REQ-028 reset asserted during MOD SHALL abort the operation with no done pulse; the first start after release behaves as after power-up.
REQ-029 Operation after reset release SHALL begin on the first rising edge at which reset is high.

Verification
REQ-030 After reset: NEXT, NEXT, PEEK -> results 32'h80200003, 32'hC0300002, 32'hC0300002; each done one cycle after its start.
REQ-031 After reset: RANGE with dataB=10 -> done exactly 33 cycles after start, result=3 (32'h80200003 mod 10); start pulses at cycles 5 and 20 ignored.
REQ-032 SEED dataB=32'h12345678 then PEEK -> 32'h12345678; SEED dataB=0 then PEEK -> 32'h00000001.
REQ-033 RANGE dataB=0 after reset -> result 32'h80200003 at latency 33; RANGE dataB=1 -> result 0.
REQ-034 RANGE with clk_en low for 5 cycles mid-MOD -> done at latency 38, result unchanged vs. uninterrupted run; done pulse still one cycle wide.
REQ-035 reset asserted asynchronously at cycle 10 of RANGE -> done=0, result=0 immediately; after release, NEXT returns 32'h80200003.
